if_stage: RTL and testbench

//   MIPS pipeline instruction-fetch stage and IF/ID pipeline register. Owns the PC, issues
//   one-outstanding-request fetches to instruction memory, and presents instr/PC+4 to ID.

---
 rtl/if_stage.sv | 116 +++++++++++
 tb/tb_if_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: owns the PC, keeps at most one imem fetch in flight,
// and drives the IF/ID register. Fetches that turn out to be wrong-path are discarded.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        write_pc_ir,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4
);

  typedef enum logic [1:0] {REQ, WAIT, DROP, HELD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt, held_instr, held_nxt;
  logic [31:0] id_instr_nxt, id_pc4_nxt;
  logic        id_valid_nxt;
  logic        accept, redirect, have_instr;
  logic [31:0] tgt, pc4, instr;

  assign imem_req_valid = (state == REQ) && !rst;
  assign imem_addr      = pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign redirect       = write_pc_ir && (jump || branch);
  assign tgt            = jump ? jump_target : branch_target;
  assign pc4            = pc + 32'd4;

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    held_nxt     = held_instr;
    id_valid_nxt = id_valid;
    id_instr_nxt = id_instr;
    id_pc4_nxt   = id_pc4;
    have_instr   = 1'b0;
    instr        = NOP_INSTR;

    case (state)
      REQ: begin
        if (accept) state_nxt = redirect ? DROP : WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          have_instr = 1'b1;
          instr      = imem_rsp_data;
          if (write_pc_ir) begin
            state_nxt = REQ;
          end else begin
            held_nxt  = imem_rsp_data;
            state_nxt = HELD;
          end
        end else if (redirect) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (imem_rsp_valid) state_nxt = REQ;
      end
      HELD: begin
        have_instr = 1'b1;
        instr      = held_instr;
        if (write_pc_ir) state_nxt = REQ;
      end
      default: state_nxt = REQ;
    endcase

    // Redirect outranks any available instruction: it is on the wrong path.
    if (redirect) begin
      pc_nxt       = tgt;
      id_valid_nxt = 1'b0;
      id_instr_nxt = NOP_INSTR;
    end else if (write_pc_ir) begin
      if (have_instr) begin
        pc_nxt       = pc4;
        id_valid_nxt = 1'b1;
        id_instr_nxt = instr;
        id_pc4_nxt   = pc4;
      end else begin
        id_valid_nxt = 1'b0;
        id_instr_nxt = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= REQ;
      pc         <= RESET_PC;
      held_instr <= NOP_INSTR;
      id_valid   <= 1'b0;
      id_instr   <= NOP_INSTR;
      id_pc4     <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      held_instr <= held_nxt;
      id_valid   <= id_valid_nxt;
      id_instr   <= id_instr_nxt;
      id_pc4     <= id_pc4_nxt;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a simple fixed-latency imem model driven per cycle.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        write_pc_ir;
  logic        branch;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;

  int unsigned n_checks = 0;
  int unsigned n_errs   = 0;

  logic        pend;
  logic [31:0] pend_addr;
  int unsigned cnt;
  int unsigned lat;

  if_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .write_pc_ir    (write_pc_ir),
    .branch         (branch),
    .branch_target  (branch_target),
    .jump           (jump),
    .jump_target    (jump_target),
    .pc             (pc),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc4         (id_pc4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    return 32'h2000_0000 + a;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: sample request handshake before the edge, then advance the imem model.
  task automatic step();
    logic        acc, rst_s;
    logic [31:0] addr_s;
    acc    = imem_req_valid & imem_req_ready;
    rst_s  = rst;
    addr_s = imem_addr;
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    if (rst_s) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend           = 1'b0;
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = instr_at(pend_addr);
        end
      end
      if (acc) begin
        pend_addr = addr_s;
        cnt       = lat - 1;
        if (cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = instr_at(addr_s);
        end else begin
          pend = 1'b1;
        end
      end
    end
  endtask

  task automatic expect_id(input string tag, input logic [31:0] a);
    check({tag, "_valid"}, {31'd0, id_valid}, 32'd1);
    check({tag, "_instr"}, id_instr, instr_at(a));
    check({tag, "_pc4"},   id_pc4,   a + 32'd4);
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    write_pc_ir = 1'b1; branch = 1'b0; jump = 1'b0;
    branch_target = '0; jump_target = '0;
    pend = 1'b0; pend_addr = '0; cnt = 0; lat = 1;

    // 1. reset then straight-line fetch
    step(); step();
    check("rst_pc", pc, 32'h0);
    check("rst_id_valid", {31'd0, id_valid}, 32'd0);
    check("rst_id_instr", id_instr, 32'h0);
    check("rst_id_pc4", id_pc4, 32'h0);
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("seq_addr", imem_addr, 32'(4 * k));
      check("seq_req", {31'd0, imem_req_valid}, 32'd1);
      step();
      check("seq_bubble", {31'd0, id_valid}, 32'd0);
      step();
      expect_id("seq_id", 32'(4 * k));
    end
    check("seq_pc", pc, 32'd12);

    // 2. response arrives while ID is stalled
    write_pc_ir = 1'b0;
    step(); step();
    check("held_req", {31'd0, imem_req_valid}, 32'd0);
    step();
    check("held_req2", {31'd0, imem_req_valid}, 32'd0);
    check("held_pc", pc, 32'd12);
    check("held_id_instr", id_instr, instr_at(32'd8));
    check("held_id_pc4", id_pc4, 32'd12);
    write_pc_ir = 1'b1;
    step();
    expect_id("rel_id", 32'd12);
    check("rel_addr", imem_addr, 32'd16);
    check("rel_req", {31'd0, imem_req_valid}, 32'd1);

    // 3. jump while WAIT with 2-cycle imem latency
    lat = 2;
    step();
    jump = 1'b1; jump_target = 32'h40;
    step();
    jump = 1'b0;
    check("jmp_pc", pc, 32'h40);
    check("jmp_req", {31'd0, imem_req_valid}, 32'd0);
    step();
    check("jmp_addr", imem_addr, 32'h40);
    check("jmp_req2", {31'd0, imem_req_valid}, 32'd1);
    check("jmp_drop", {31'd0, id_valid}, 32'd0);
    lat = 1;
    step(); step();
    expect_id("jmp_id", 32'h40);

    // 4. branch and jump together, then branch under stall ignored
    branch = 1'b1; jump = 1'b1; branch_target = 32'h80; jump_target = 32'hC0;
    step();
    branch = 1'b0; jump = 1'b0;
    check("bj_pc", pc, 32'hC0);
    step();
    check("bj_addr", imem_addr, 32'hC0);
    check("bj_bubble", {31'd0, id_valid}, 32'd0);
    write_pc_ir = 1'b0; branch = 1'b1; branch_target = 32'h80;
    step(); step();
    check("brstall_pc", pc, 32'hC0);
    branch = 1'b0; write_pc_ir = 1'b1;
    step();
    expect_id("brstall_id", 32'hC0);

    // 5. imem not ready, then redirect without accept
    imem_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("nrdy_addr", imem_addr, 32'hC4);
      check("nrdy_req", {31'd0, imem_req_valid}, 32'd1);
      check("nrdy_bubble", {31'd0, id_valid}, 32'd0);
    end
    jump = 1'b1; jump_target = 32'h100;
    step();
    jump = 1'b0;
    check("nrdy_redir_addr", imem_addr, 32'h100);
    check("nrdy_redir_req", {31'd0, imem_req_valid}, 32'd1);
    imem_req_ready = 1'b1;
    step(); step();
    expect_id("nrdy_id", 32'h100);

    // 6. reset mid-WAIT, then pc wrap
    lat = 2;
    step();
    rst = 1'b1;
    step();
    check("mrst_pc", pc, 32'h0);
    check("mrst_valid", {31'd0, id_valid}, 32'd0);
    rst = 1'b0;
    #1;
    check("mrst_req", {31'd0, imem_req_valid}, 32'd1);
    check("mrst_addr", imem_addr, 32'h0);
    lat = 1;
    step(); step();
    expect_id("mrst_id", 32'h0);
    imem_req_ready = 1'b0; jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    step();
    jump = 1'b0; imem_req_ready = 1'b1;
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    step(); step();
    check("wrap_instr", id_instr, 32'h1FFF_FFFC);
    check("wrap_pc4", id_pc4, 32'h0);
    check("wrap_pc", pc, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errs);
    $finish;
  end

endmodule
